lfsr_stream_gen: RTL and testbench
==================================

// Module: lfsr_stream_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random word source with a valid/ready output,
//  runtime reseeding and a configurable number of shift steps per emitted word.
//  Feeds the image-generation colour and pattern pipeline where downstream stages
//  may stall. Successor to the fixed 16-bit free-running generator.
// PARAMETERS
//  WIDTH  16       LFSR and output word width (>=3)
//  TAPS   16'hB400 feedback mask, bit i set = state[i] XORed into feedback
//  SEED   16'h5A08 reset/default seed, must be non-zero
//  STEPS  1        LFSR shifts per emitted word (1..WIDTH)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  en         in   1      advance enable; LFSR holds when low
//  seed_load  in   1      load seed_in this cycle (pulse)
//  seed_in    in   WIDTH  runtime seed value
//  out_ready  in   1      consumer accepts rng_out when rng_valid && out_ready
//  rng_out    out  WIDTH  registered random word
//  rng_valid  out  1      rng_out holds an unconsumed word
//  lockup     out  1      one-cycle pulse: zero seed replaced (only with LFSR_LOCKUP_GUARD_EN)
// BEHAVIOUR
//  Reset (reset==0, async): state=SEED, step_cnt=0, rng_out=0, rng_valid=0, lockup=0.
//  Feedback fb = ^(state & TAPS); advance: state <= {state[WIDTH-2:0], fb}.
//  advance = en && !(rng_valid && !out_ready) && !seed_load (stall on backpressure).
//  On advance: step_cnt increments; when step_cnt==STEPS-1 it wraps to 0, and
//   rng_out <= next state, rng_valid <= 1 in the same edge (latency 1 cycle for STEPS=1).
//  rng_valid clears on handshake (valid && ready) unless a new word loads that
//   same cycle, in which case it stays 1 and rng_out takes the new word (no bubble).
//  Held word: while rng_valid && !out_ready, rng_out, state and step_cnt are frozen.
//  seed_load has priority over advance: state<=seed_in, step_cnt<=0, rng_valid<=0;
//   rng_out unchanged. Pending word is discarded.
//  en low: state/step_cnt hold; a valid word still completes its handshake.
//  Defaults reproduce the legacy sequence: 0x5A08 -> 0xB411 -> 0x6822 ...; period 65535.
//  Reset mid-operation: immediate return to reset values regardless of handshake.
// CONFIGURATION
//  LFSR_LOCKUP_GUARD_EN defined: seed_load with seed_in==0 loads SEED instead and
//   pulses lockup for one cycle; also if state is ever zero it is forced to SEED
//   next cycle (lockup pulse), covering upsets.
//  Not defined: seed_in loaded verbatim; zero seed locks the LFSR at 0, words of 0
//   are still emitted; lockup tied 0.
// STRUCTURE
//  Package lfsr_pkg: default TAPS/SEED localparams, lfsr_step() function
//   (WIDTH-generic next-state), step counter width via $clog2(STEPS+1).
//  No sub-modules; single always_ff for state/counter/output plus comb feedback.
// TESTING
//  1 reset, en=1, out_ready=1, defaults -> rng_out 0xB411 cycle 1, 0x6822 cycle 2,
//    rng_valid high from cycle 1 onward.
//  2 out_ready=0 after first word -> rng_out holds 0xB411, state frozen 10 cycles;
//    raise out_ready -> 0x6822 next cycle, no skipped value.
//  3 STEPS=4 -> rng_valid first rises 4 cycles after en; words equal every 4th
//    state of STEPS=1 run.
//  4 seed_load=1, seed_in=0x0001 with en=1 same cycle -> rng_valid 0 next cycle,
//    next word = lfsr_step(0x0001)=0x0002.
//  5 free run 65535 advances from 0x5A08 -> state returns to 0x5A08, never 0.
//  6 seed_in=0: with LFSR_LOCKUP_GUARD_EN -> state 0x5A08, lockup 1 cycle;
//    without -> rng_out stays 0x0000, lockup 0. Async reset mid-stall -> all reset values.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared defaults and helper functions for the LFSR word source
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W          = 64;
    localparam logic [15:0] LFSR_DEFAULT_TAPS   = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED   = 16'h5A08;

    // Width-generic Fibonacci step: the caller zero-extends to LFSR_MAX_W and truncates the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (width >= LFSR_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
    endfunction

    function automatic int unsigned step_cnt_width(input int unsigned steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - Fibonacci LFSR word source with valid/ready output and reseeding
// Optional zero-state recovery is enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
    parameter int unsigned      STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rng_out,
    output logic             rng_valid,
    output logic             lockup
);

    localparam int unsigned CNT_W = step_cnt_width(STEPS);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic [CNT_W-1:0] step_cnt;
    logic             stall;
    logic             advance;
    logic             handshake;
    logic             word_done;

    assign next_state = WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH));
    assign stall      = rng_valid && !out_ready;
    assign handshake  = rng_valid && out_ready;
    assign advance    = en && !stall && !seed_load;
    assign word_done  = advance && (step_cnt == CNT_W'(STEPS - 1));

`ifdef LFSR_LOCKUP_GUARD_EN
    logic lockup_q;
    assign lockup = lockup_q;
`else
    assign lockup = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEED;
            step_cnt  <= '0;
            rng_out   <= '0;
            rng_valid <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
            lockup_q  <= 1'b0;
`endif
        end else begin
`ifdef LFSR_LOCKUP_GUARD_EN
            lockup_q <= 1'b0;
`endif
            if (seed_load) begin
                // A reseed discards any pending word; rng_out keeps its last value.
                step_cnt  <= '0;
                rng_valid <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
                if (seed_in == '0) begin
                    state    <= SEED;
                    lockup_q <= 1'b1;
                end else begin
                    state <= seed_in;
                end
`else
                state <= seed_in;
`endif
            end
`ifdef LFSR_LOCKUP_GUARD_EN
            else if (state == '0) begin
                state    <= SEED;
                lockup_q <= 1'b1;
                if (handshake) rng_valid <= 1'b0;
            end
`endif
            else if (advance) begin
                state <= next_state;
                if (word_done) begin
                    // New word replaces a consumed one in the same edge, so no bubble.
                    step_cnt  <= '0;
                    rng_out   <= next_state;
                    rng_valid <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (handshake) rng_valid <= 1'b0;
                end
            end else if (handshake) begin
                rng_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb/tb_lfsr_stream_gen.sv - randomized and directed checks of lfsr_stream_gen against a reference model
module tb_lfsr_stream_gen;

    localparam logic [15:0] TAPS_REF = 16'hB400;
    localparam logic [15:0] SEED_REF = 16'h5A08;
`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        out_ready;
    logic [15:0] out1, out4;
    logic        valid1, valid4, lock1, lock4;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_stream_gen u_dut1 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_ready(out_ready), .rng_out(out1), .rng_valid(valid1), .lockup(lock1)
    );

    lfsr_stream_gen #(.STEPS(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .out_ready(out_ready), .rng_out(out4), .rng_valid(valid4), .lockup(lock4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 models STEPS=1, index 1 models STEPS=4.
    int          steps_of [2] = '{1, 4};
    logic [15:0] m_state  [2];
    logic [15:0] m_out    [2];
    int          m_shifts [2];
    bit          m_valid  [2];
    bit          m_lock   [2];

    function automatic logic [15:0] ref_next(input logic [15:0] x);
        int ones = 0;
        for (int i = 0; i < 16; i++) if (TAPS_REF[i] && x[i]) ones++;
        return {x[14:0], (ones % 2) == 1};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i]  = SEED_REF;
            m_out[i]    = 16'h0;
            m_shifts[i] = 0;
            m_valid[i]  = 1'b0;
            m_lock[i]   = 1'b0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            bit consumed = m_valid[i] && out_ready;
            m_lock[i] = 1'b0;
            if (seed_load) begin
                m_shifts[i] = 0;
                m_valid[i]  = 1'b0;
                if (GUARD && seed_in == 16'h0) begin
                    m_state[i] = SEED_REF;
                    m_lock[i]  = 1'b1;
                end else begin
                    m_state[i] = seed_in;
                end
            end else if (GUARD && m_state[i] == 16'h0) begin
                m_state[i] = SEED_REF;
                m_lock[i]  = 1'b1;
                if (consumed) m_valid[i] = 1'b0;
            end else if (en && !(m_valid[i] && !out_ready)) begin
                m_state[i]  = ref_next(m_state[i]);
                m_shifts[i] = m_shifts[i] + 1;
                if (m_shifts[i] == steps_of[i]) begin
                    m_shifts[i] = 0;
                    m_out[i]    = m_state[i];
                    m_valid[i]  = 1'b1;
                end else if (consumed) begin
                    m_valid[i] = 1'b0;
                end
            end else if (consumed) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out1"},   32'(out1),   32'(m_out[0]));
        check({tag, ".valid1"}, 32'(valid1), 32'(m_valid[0]));
        check({tag, ".lock1"},  32'(lock1),  32'(m_lock[0]));
        check({tag, ".out4"},   32'(out4),   32'(m_out[1]));
        check({tag, ".valid4"}, 32'(valid4), 32'(m_valid[1]));
        check({tag, ".lock4"},  32'(lock4),  32'(m_lock[1]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_model("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [15:0] seq4, seq8;
    bit          zero_seen;

    initial begin
        reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 16'h0; out_ready = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Default sequence and STEPS=4 sampling of it
        seq4 = SEED_REF;
        for (int i = 0; i < 4; i++) seq4 = ref_next(seq4);
        seq8 = seq4;
        for (int i = 0; i < 4; i++) seq8 = ref_next(seq8);
        en = 1'b1; out_ready = 1'b1;
        tick("t1c1");
        check("t1_word1", 32'(out1), 32'h0000B411);
        check("t1_valid1", 32'(valid1), 32'h1);
        check("t3_valid_c1", 32'(valid4), 32'h0);
        tick("t1c2");
        check("t1_word2", 32'(out1), 32'h00006822);
        tick("t1c3");
        check("t3_valid_c3", 32'(valid4), 32'h0);
        tick("t1c4");
        check("t3_valid_c4", 32'(valid4), 32'h1);
        check("t3_word4", 32'(out4), 32'(seq4));
        for (int i = 0; i < 4; i++) tick("t3run");
        check("t3_word8", 32'(out4), 32'(seq8));

        // Backpressure hold then release
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        tick("t2first");
        for (int i = 0; i < 10; i++) begin
            tick("t2hold");
            check("t2_held", 32'(out1), 32'h0000B411);
        end
        out_ready = 1'b1;
        tick("t2rel");
        check("t2_release", 32'(out1), 32'h00006822);

        // Reseed with en high: seed_load wins
        seed_load = 1'b1; seed_in = 16'h0001;
        tick("t4load");
        check("t4_valid_cleared", 32'(valid1), 32'h0);
        seed_load = 1'b0;
        tick("t4next");
        check("t4_word", 32'(out1), 32'h00000002);

        // Zero seed handling
        seed_load = 1'b1; seed_in = 16'h0000;
        tick("t6load");
        check("t6_lockup", 32'(lock1), GUARD ? 32'h1 : 32'h0);
        seed_load = 1'b0;
        tick("t6next");
        check("t6_word", 32'(out1), GUARD ? 32'h0000B411 : 32'h0);
        check("t6_lockup_after", 32'(lock1), 32'h0);

        // Async reset during a stall
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("t6stall");
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_out", 32'(out1), 32'h0);
        check("rst_mid_valid", 32'(valid1), 32'h0);
        check("rst_mid_lock", 32'(lock1), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Full period
        en = 1'b1; out_ready = 1'b1; seed_load = 1'b0;
        zero_seen = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            tick("t5run");
            if (out1 == 16'h0) zero_seen = 1'b1;
        end
        check("t5_period", 32'(out1), 32'(SEED_REF));
        check("t5_never_zero", 32'(zero_seen), 32'h0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            seed_load = ($urandom_range(0, 30) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 600) == 0) do_reset();
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
